param_data_path: RTL and testbench

- Parametrised, multi-cycle successor to the 4-bit single-cycle datapath.
- Contains a program counter, a REG_N x DATA_W register file, an ALU with registered flags, and a fetch/decode/execute/writeback FSM.
- Fetches 16-bit instructions from external instruction memory through a req/valid handshake.
- Sits between instruction memory and the debug/trace bus; `result` is the observable output.

---
 rtl/dp_pkg.sv | 44 ++++
 rtl/dp_alu.sv | 48 ++++
 rtl/param_data_path.sv | 161 ++++++++++++++++
 tb/tb_param_data_path.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the parametrised multi-cycle datapath:
// opcodes, FSM states, instruction field positions and decode helpers.
package dp_pkg;

    // 4-bit opcode field; unlisted encodings execute as NOP
    typedef enum logic [3:0] {
        OpNop  = 4'd0,
        OpAnd  = 4'd1,
        OpOr   = 4'd2,
        OpAdd  = 4'd3,
        OpSub  = 4'd4,
        OpSlt  = 4'd5,
        OpLdi  = 4'd6,
        OpBeqz = 4'd7,
        OpHalt = 4'd15
    } op_e;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalted
    } state_e;

    // Instruction field positions
    localparam int unsigned OpLsb  = 12;
    localparam int unsigned RdLsb  = 9;
    localparam int unsigned Rs1Lsb = 6;
    localparam int unsigned Rs2Lsb = 3;
    localparam int unsigned ImmW   = 6;
    localparam int unsigned TgtW   = 8;

    // Opcodes that write the destination register in WB
    function automatic logic op_writes_reg(input logic [3:0] op);
        return op inside {OpAnd, OpOr, OpAdd, OpSub, OpSlt, OpLdi};
    endfunction

    // Opcodes that update the status flags in EXEC
    function automatic logic op_sets_flags(input logic [3:0] op);
        return op inside {OpAnd, OpOr, OpAdd, OpSub, OpSlt};
    endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for param_data_path. Produces result, carry and signed
// overflow; zero/sign flags are derived from the result by the caller.
module dp_alu
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              cf,
    output logic              of
);

    localparam int unsigned Msb = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // diff[DATA_W] is the borrow out of the subtraction
    assign diff = {1'b0, a} - {1'b0, b};

    // Operation select; carry/overflow are only meaningful for ADD/SUB
    always_comb begin
        result = '0;
        cf     = 1'b0;
        of     = 1'b0;
        case (op)
            OpAnd: result = a & b;
            OpOr:  result = a | b;
            OpAdd: begin
                result = sum[DATA_W-1:0];
                cf     = sum[DATA_W];
                of     = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
            end
            OpSub: begin
                result = diff[DATA_W-1:0];
                cf     = ~diff[DATA_W];
                of     = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
            end
            OpSlt: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: ;
        endcase
    end

endmodule

// File: rtl/param_data_path.sv
// Parametrised multi-cycle datapath: PC, REG_N x DATA_W register file, ALU
// with registered flags and a FETCH/DECODE/EXEC/WB FSM fetching 16-bit
// instructions over a req/valid handshake.
// Optional feature: define DP_BRANCH_EN to enable op 7 (BEQZ); otherwise
// op 7 executes as NOP.
module param_data_path
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_N  = 4,
    parameter int unsigned PC_W   = 8
) (
    input  logic              clk,
    input  logic              clr,
    output logic              instr_req,
    output logic [PC_W-1:0]   instr_addr,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              zf,
    output logic              cf,
    output logic              of,
    output logic              sf,
    output logic              halted
);

    // Only the low index bits that can address REG_N registers are used
    localparam int unsigned IdxW = (REG_N > 1) ? $clog2(REG_N) : 1;

    state_e            state;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic [3:0]        op;
    logic [IdxW-1:0]   rd_idx;
    logic [IdxW-1:0]   rs1_idx;
    logic [IdxW-1:0]   rs2_idx;
    logic              rd_ok;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W+ImmW-1:0] imm_wide;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cf;
    logic              alu_of;
    logic [DATA_W-1:0] exec_result;
    logic [PC_W-1:0]   pc_next;
    logic              unused_ir;

    dp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result),
        .cf     (alu_cf),
        .of     (alu_of)
    );

    assign op      = ir[OpLsb +: 4];
    assign rd_idx  = ir[RdLsb +: IdxW];
    assign rs1_idx = ir[Rs1Lsb +: IdxW];
    assign rs2_idx = ir[Rs2Lsb +: IdxW];
    // Bits outside the decoded fields are don't-care
    assign unused_ir = ^ir;

    // Register reads, immediate extension and next-PC selection
    always_comb begin
        rd_ok    = (32'(rd_idx) < REG_N);
        rs1_val  = (32'(rs1_idx) < REG_N) ? regs[rs1_idx] : '0;
        rs2_val  = (32'(rs2_idx) < REG_N) ? regs[rs2_idx] : '0;
        imm_wide = {{DATA_W{1'b0}}, ir[ImmW-1:0]};
        imm      = imm_wide[DATA_W-1:0];
        exec_result = (op == OpLdi) ? imm : alu_result;
        pc_next  = pc + PC_W'(1);
`ifdef DP_BRANCH_EN
        begin
            logic [PC_W+TgtW-1:0] tgt_wide;
            tgt_wide = {{PC_W{1'b0}}, ir[TgtW-1:0]};
            // zf here still reflects the last flag-setting op: BEQZ never updates flags
            if (op == OpBeqz && zf) begin
                pc_next = tgt_wide[PC_W-1:0];
            end
        end
`endif
    end

    // Fetch request is dropped while reset is held so all outputs read 0
    assign instr_req  = (state == StFetch) && clr;
    assign instr_addr = pc;

    // Core FSM with register file, operand latches, result and flags
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= StFetch;
            pc           <= '0;
            ir           <= '0;
            op_a         <= '0;
            op_b         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            zf           <= 1'b0;
            cf           <= 1'b0;
            of           <= 1'b0;
            sf           <= 1'b0;
            halted       <= 1'b0;
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= DATA_W'(2 * (i + 1));
            end
        end else begin
            result_valid <= 1'b0;
            case (state)
                StFetch: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= StDecode;
                    end
                end
                StDecode: begin
                    op_a  <= rs1_val;
                    op_b  <= rs2_val;
                    state <= StExec;
                end
                StExec: begin
                    if (op == OpHalt) begin
                        halted <= 1'b1;
                        state  <= StHalted;
                    end else begin
                        if (op_writes_reg(op)) begin
                            result       <= exec_result;
                            // Registered here so the pulse lines up with the WB cycle
                            result_valid <= 1'b1;
                        end
                        if (op_sets_flags(op)) begin
                            zf <= (alu_result == '0);
                            sf <= alu_result[DATA_W-1];
                            cf <= alu_cf;
                            of <= alu_of;
                        end
                        state <= StWb;
                    end
                end
                StWb: begin
                    if (op_writes_reg(op) && rd_ok) begin
                        regs[rd_idx] <= result;
                    end
                    pc    <= pc_next;
                    state <= StFetch;
                end
                StHalted: state <= StHalted;
                default:  state <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_param_data_path.sv
// Self-checking bench for param_data_path: random programs against a
// behavioural model, with a scoreboard queue checked by a WB monitor.
module tb_param_data_path;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic [7:0]  result;
    logic        result_valid, zf, cf, of, sf, halted;

    // Second instance with a 4-bit PC for the wrap check
    logic        clr4 = 1'b1;
    logic        instr_valid4 = 1'b1;
    logic [15:0] instr4 = '0;
    logic        instr_req4;
    logic [3:0]  instr_addr4;
    logic [7:0]  result4;
    logic        result_valid4, zf4, cf4, of4, sf4, halted4;

    param_data_path #(.DATA_W(8), .REG_N(4), .PC_W(8)) u_dut (
        .clk          (clk),
        .clr          (clr),
        .instr_req    (instr_req),
        .instr_addr   (instr_addr),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .result       (result),
        .result_valid (result_valid),
        .zf           (zf),
        .cf           (cf),
        .of           (of),
        .sf           (sf),
        .halted       (halted)
    );

    param_data_path #(.DATA_W(8), .REG_N(4), .PC_W(4)) u_dut4 (
        .clk          (clk),
        .clr          (clr4),
        .instr_req    (instr_req4),
        .instr_addr   (instr_addr4),
        .instr_valid  (instr_valid4),
        .instr        (instr4),
        .result       (result4),
        .result_valid (result_valid4),
        .zf           (zf4),
        .cf           (cf4),
        .of           (of4),
        .sf           (sf4),
        .halted       (halted4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] res;
        logic       zf;
        logic       cf;
        logic       of;
        logic       sf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    int   m_regs[4];
    int   m_pc;
    logic m_zf, m_cf, m_of, m_sf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 2 * (i + 1);
        m_pc = 0;
        m_zf = 1'b0; m_cf = 1'b0; m_of = 1'b0; m_sf = 1'b0;
        exp_q.delete();
    endtask

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Architectural effect of one instruction, in plain integer arithmetic
    task automatic model_step(input logic [15:0] w);
        int op, rd, rs1, rs2, a, b, sa, sb, r, next_pc;
        bit wr, fl;
        logic c, o;
        exp_t e;
        op  = int'(w[15:12]);
        rd  = int'(w[11:9]) % 4;
        rs1 = int'(w[8:6]) % 4;
        rs2 = int'(w[5:3]) % 4;
        a = m_regs[rs1]; b = m_regs[rs2];
        sa = to_signed8(a); sb = to_signed8(b);
        r = 0; wr = 0; fl = 0; c = 1'b0; o = 1'b0;
        case (op)
            1: begin r = a & b; wr = 1; fl = 1; end
            2: begin r = a | b; wr = 1; fl = 1; end
            3: begin
                r = (a + b) % 256; c = (a + b > 255);
                o = (sa + sb > 127) || (sa + sb < -128); wr = 1; fl = 1;
            end
            4: begin
                r = (a - b + 256) % 256; c = (a >= b);
                o = (sa - sb > 127) || (sa - sb < -128); wr = 1; fl = 1;
            end
            5: begin r = (sa < sb) ? 1 : 0; wr = 1; fl = 1; end
            6: begin r = int'(w[5:0]); wr = 1; end
            default: ;
        endcase
        if (fl) begin
            m_zf = (r == 0); m_sf = (r >= 128); m_cf = c; m_of = o;
        end
        if (wr) begin
            m_regs[rd] = r;
            e.res = 8'(r); e.zf = m_zf; e.cf = m_cf; e.of = m_of; e.sf = m_sf;
            exp_q.push_back(e);
        end
        if (op != 15) begin
            next_pc = (m_pc + 1) % 256;
`ifdef DP_BRANCH_EN
            if (op == 7 && m_zf) next_pc = int'(w[7:0]);
`endif
            m_pc = next_pc;
        end
    endtask

    // Present one instruction, optionally stalling the fetch for 'waits' cycles
    task automatic issue(input logic [15:0] w, input int waits);
        int n = 0;
        @(negedge clk);
        while (!instr_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req", instr_req, 1);
        check("fetch_addr", instr_addr, m_pc);
        for (int k = 0; k < waits; k++) begin
            instr_valid = 1'b0;
            @(negedge clk);
            check("hold_req", instr_req, 1);
            check("hold_addr", instr_addr, m_pc);
            check("hold_no_wb", result_valid, 0);
        end
        instr_valid = 1'b1;
        instr = w;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        model_step(w);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        #1;
        check("rst_req", instr_req, 0);
        check("rst_addr", instr_addr, 0);
        check("rst_result", result, 0);
        check("rst_rv", result_valid, 0);
        check("rst_flags", {zf, cf, of, sf}, 0);
        check("rst_halted", halted, 0);
        model_reset();
        @(negedge clk);
        clr = 1'b1;
    endtask

    // Scoreboard monitor: every WB pulse consumes one expected entry
    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        if (result_valid) begin
            check("rv_single_cycle", rv_prev, 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: result 0x%0h with no pending expectation", result);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_result", result, mon_e.res);
                check("wb_flags_zcos", {zf, cf, of, sf}, {mon_e.zf, mon_e.cf, mon_e.of, mon_e.sf});
            end
        end
        rv_prev = result_valid;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] ops [10];
        int n;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12};
        #1 clr4 = 1'b0;
        #1 do_reset();

        // Directed sequence from the test plan
        issue(16'h3650, 0);
        issue(16'h4000, 0);
        issue(16'h623F, 0);
        issue(16'h3448, 0);
        issue(16'h3490, 0);
        issue(16'h3650, 5);

        // Branch taken (if enabled) after a zero result
        do_reset();
        issue(16'h4000, 0);
        issue(16'h7005, 0);
        @(negedge clk);
        n = 0;
        while (!instr_req && n < 20) begin
            @(negedge clk);
            n++;
        end
`ifdef DP_BRANCH_EN
        check("branch_addr", instr_addr, 5);
`else
        check("branch_addr", instr_addr, 2);
`endif

        // Random programs
        for (int i = 0; i < 150; i++) begin
            logic [15:0] w;
            w = {ops[$urandom_range(0, 9)], 12'($urandom)};
            issue(w, $urandom_range(0, 2));
        end

        // Reset asserted during EXEC, then registers back to 2,4,6,8
        issue(16'h3650, 0);
        @(posedge clk);
        #1;
        do_reset();
        issue(16'h3018, 0);
        issue(16'h3650, 1);

        // HALT
        issue(16'hF000, 0);
        n = 0;
        while (!halted && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("halted", halted, 1);
        check("queue_drained", exp_q.size(), 0);
        repeat (20) begin
            @(negedge clk);
            check("halt_req", instr_req, 0);
            check("halt_stays", halted, 1);
        end

        // 4-bit PC wraps from 15 to 0 under a stream of NOPs
        @(posedge clk);
        #1 clr4 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            n = 0;
            while (!instr_req4 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("pc4_addr", instr_addr4, i % 16);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
